// File: rtl/imem_boot_ctrl_pkg.sv
// Shared constants for the instruction memory: the boot image, the NOP filler
// word and the init/run state type.
package simpu_imem_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [31:0] BOOT_IMAGE [0:3] = '{
    32'h6842000A, 32'h6884000C, 32'h40C22000, 32'h40C41000
  };

  typedef enum logic {INIT, RUN} imem_state_t;

  // Boot-image entry for a word index; NOP once past the end of the image.
  function automatic logic [31:0] boot_word(input logic [31:0] idx);
    if (idx < 32'd4) return BOOT_IMAGE[idx[1:0]];
    return NOP;
  endfunction

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Fetch, program-load and status signals between the fetch/loader side
// (master) and the instruction memory (slave).
interface imem_boot_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              busy;
  logic              parity_err;

  modport master (
    output fetch_req, fetch_addr, wr_en, wr_addr, wr_data,
    input  fetch_ready, fetch_valid, fetch_data, fetch_err, wr_ack, busy, parity_err
  );

  modport slave (
    input  fetch_req, fetch_addr, wr_en, wr_addr, wr_data,
    output fetch_ready, fetch_valid, fetch_data, fetch_err, wr_ack, busy, parity_err
  );

endinterface

// File: rtl/imem_boot_ctrl_init_seq.sv
// Init sequencer: after reset walks every memory word once, presenting the
// boot image for the low words and NOP for the rest, then parks in RUN.
module imem_init_seq
  import simpu_imem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 256,
  parameter int BOOT_WORDS = 4,
  parameter int AW         = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              init_we,
  output logic [AW-1:0]     init_addr,
  output logic [DATA_W-1:0] init_data
);

  imem_state_t   state;
  logic [AW-1:0] init_ptr;

  // One word per cycle; leaving INIT after the last word is written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      init_ptr <= '0;
      busy     <= 1'b1;
    end else if (state == INIT) begin
      init_ptr <= init_ptr + AW'(1);
      if (init_ptr == AW'(DEPTH - 1)) begin
        state <= RUN;
        busy  <= 1'b0;
      end
    end
  end

  assign init_we   = (state == INIT);
  assign init_addr = init_ptr;
  assign init_data = (32'(init_ptr) < 32'(BOOT_WORDS)) ? DATA_W'(boot_word(32'(init_ptr)))
                                                       : DATA_W'(NOP);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Instruction memory with hardware boot loader, registered fetch port and
// program-load write port. Optional IMEM_PARITY_EN adds a stored even-parity bit.
module imem_boot_ctrl
  import simpu_imem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 256,
  parameter int BOOT_WORDS = 4
) (
  input logic             clk,
  input logic             reset,
  imem_boot_ctrl_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int SW = DATA_W + 1;
`else
  localparam int SW = DATA_W;
`endif

  logic [SW-1:0]     mem [0:DEPTH-1];
  logic              busy;
  logic              init_we;
  logic [AW-1:0]     init_addr;
  logic [DATA_W-1:0] init_data;
  logic [SW-1:0]     init_word;
  logic [SW-1:0]     wr_word;
  logic [SW-1:0]     rd_word;
  logic              wr_hit;
  logic              fetch_acc;
  logic              fetch_in_range;

  imem_init_seq #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .BOOT_WORDS(BOOT_WORDS), .AW(AW)
  ) u_init_seq (
    .clk(clk), .reset(reset), .busy(busy),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

`ifdef IMEM_PARITY_EN
  assign init_word = {^init_data, init_data};
  assign wr_word   = {^bus.wr_data, bus.wr_data};
`else
  assign init_word = init_data;
  assign wr_word   = bus.wr_data;
`endif

  assign bus.busy        = busy;
  assign bus.fetch_ready = ~busy;
  assign fetch_acc       = bus.fetch_req & ~busy;
  assign fetch_in_range  = ({1'b0, bus.fetch_addr} < DEPTH_L);
  assign wr_hit          = bus.wr_en & ~busy & ({1'b0, bus.wr_addr} < DEPTH_L);
  assign rd_word         = mem[bus.fetch_addr[AW-1:0]];

  // Init sequencer owns the write port until it finishes; loader writes after.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_word;
    end else if (wr_hit) begin
      mem[bus.wr_addr[AW-1:0]] <= wr_word;
    end
  end

  // Registered fetch response; reads see pre-edge contents, giving read-before-write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.fetch_valid <= 1'b0;
      bus.fetch_data  <= '0;
      bus.fetch_err   <= 1'b0;
      bus.wr_ack      <= 1'b0;
    end else begin
      bus.fetch_valid <= fetch_acc;
      bus.wr_ack      <= wr_hit;
      bus.fetch_err   <= fetch_acc & ~fetch_in_range;
      if (fetch_acc) begin
        bus.fetch_data <= fetch_in_range ? rd_word[DATA_W-1:0] : DATA_W'(NOP);
      end
    end
  end

`ifdef IMEM_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.parity_err <= 1'b0;
    end else begin
      bus.parity_err <= fetch_acc & fetch_in_range &
                        ((^rd_word[DATA_W-1:0]) != rd_word[DATA_W]);
    end
  end
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
